lif_tdm_scheduler: RTL
======================

# lif_tdm_scheduler

Time-multiplexed sequencer sharing a single leaky-integrate-and-fire update unit among N_NEURONS virtual neurons. On each `tick`, one sweep updates every neuron's membrane in index order and emits each resulting spike as an indexed event on a valid/ready port. The block sits between the input-current fabric and downstream spike consumers, replacing per-neuron LIF instances in multi-neuron builds.

## Interface
- N_NEURONS, 4: number of virtual neurons (≥2); IDXW = clog2(N_NEURONS).
- WIDTH, 8: membrane and input-current width, unsigned.
- THRESHOLD, 200: fire threshold; spike when updated membrane ≥ THRESHOLD.
- LEAK_SHIFT, 1: leak amount = membrane >> LEAK_SHIFT.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  sweep request; sampled only in IDLE.
- current_in  in  N_NEURONS*WIDTH  per-neuron input current; neuron i is bits [i*WIDTH +: WIDTH].
- spike_valid  out  1  spike event valid.
- spike_ready  in  1  downstream accepts the event.
- spike_idx  out  IDXW  index of the spiking neuron.
- busy  out  1  high in every state except IDLE.
- sweep_done  out  1  one-cycle pulse at the end of a sweep.
- overrun  out  1  sticky: a tick arrived while not IDLE.
- mon_idx  in  IDXW  monitor select.
- mon_state  out  WIDTH  combinational read of membrane[mon_idx].

## Operation
- Storage: N_NEURONS membrane registers, a latched current vector, index pointer `idx`, FSM.
- FSM states: IDLE, UPDATE, EMIT, DONE.
- IDLE: on `tick`, latch all of `current_in`, set idx=0, go to UPDATE. Later changes to `current_in` do not affect the sweep in progress.
- UPDATE (one cycle): compute sum = m − (m >> LEAK_SHIFT) + cur[idx] in WIDTH+1 bits, then saturate to 2^WIDTH−1.
  - If the result is ≥ THRESHOLD: the membrane is written to 0, `spike_idx` is set to idx, and the FSM goes to EMIT.
  - Otherwise: the membrane is written with the result. If idx = N_NEURONS−1, go to DONE; else increment idx and stay in UPDATE.
- EMIT: `spike_valid`=1 and `spike_idx` are held stable until the cycle where `spike_ready`=1 (the transfer). On transfer: go to DONE if idx is last; else increment idx and go to UPDATE.
- DONE: `sweep_done`=1 for exactly one cycle, then go to IDLE.
- A `tick` in any non-IDLE state is ignored and sets `overrun`=1. `overrun` is cleared only by `rst`.
- `idx` never wraps mid-sweep. Neurons are always visited 0..N_NEURONS−1, each exactly once per sweep.
- `rst` (any time, including mid-sweep or mid-EMIT) forces:
  - FSM to IDLE;
  - all membranes, latched currents and idx to 0;
  - `spike_valid`, `spike_idx`, `sweep_done`, `overrun` and `busy` to 0.
  - A partially emitted event is lost.

## Timing
- All outputs are registered except `mon_state`, which is combinational from `mon_idx`.
- Reset values of all outputs: 0. `mon_state` reads 0 after reset.
- `tick` sampled high at edge k:
  - `busy`=1 from after edge k.
  - Neuron i is written at edge k+1+i when no spike precedes it.
- No-spike sweep:
  - DONE occupies the cycle after edge k+N_NEURONS.
  - `sweep_done` is sampled high at edge k+N_NEURONS+1.
  - `busy` falls after that edge.
- Each spike adds 1 + (cycles with `spike_ready` low) to the sweep.
- `spike_valid` rises the cycle after the spiking UPDATE edge.
- With `spike_ready` tied high, `spike_valid` lasts exactly one cycle.
- A new `tick` is accepted at the first edge where the FSM is in IDLE, i.e. the edge right after the `sweep_done` cycle.
- `mon_state` reflects a membrane write in the cycle after that write's edge.

## Test plan
- Reset: assert `rst` asynchronously mid-sweep.
  - Required: all outputs 0 immediately, without a clock edge; all membranes read 0 via `mon_idx`; FSM back in IDLE.
- Sweep timing with currents {10,20,30,40}, tick at edge 0, `spike_ready`=1:
  - Required: membranes {10,20,30,40}; no `spike_valid`; `sweep_done` high at edge 5 only; `busy` high at edges 1–5.
- Leak and fire on neuron 2 with current 150, others 0, two sweeps:
  - Required: membrane 150 after the first sweep.
  - Second sweep: 150−75+150=225 → `spike_valid` with `spike_idx`=2; neuron 2 membrane 0; neurons 0, 1, 3 stay 0.
- Backpressure: as the previous scenario with `spike_ready` low for 3 cycles.
  - Required: `spike_valid`=1 and `spike_idx`=2 held stable 4 cycles; neuron 3 is updated only after the transfer; `sweep_done` is delayed by 3 cycles.
- Saturation with THRESHOLD=255 and current 200 on neuron 0, two sweeps:
  - Required: 200, then 200−100+200=300 saturates to 255 → spike idx 0.
  - A wrapped result (44) would not spike; a missing spike flags a wrap bug.
- Overrun: tick at edge 0, again at edge 2, with `current_in` changed at edge 1.
  - Required: `overrun`=1 from after edge 2 and stays set.
  - Only one sweep occurs; it uses the values latched at edge 0.
  - A tick at the edge right after `sweep_done` starts a new sweep.

Source files
------------

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed LIF sequencer: one shared leak/integrate/fire datapath sweeps all
// virtual neurons in index order per tick and emits spikes on a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for tick; currents latched on accept
// UPDATE | one neuron per cycle: leak, integrate, saturate, compare
// EMIT   | spike event held on spike_valid/spike_idx until spike_ready
// DONE   | one-cycle sweep_done, then back to IDLE
module lif_tdm_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 1,
    localparam int IDXW      = $clog2(N_NEURONS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [N_NEURONS*WIDTH-1:0] current_in,
    output logic                       spike_valid,
    input  logic                       spike_ready,
    output logic [IDXW-1:0]            spike_idx,
    output logic                       busy,
    output logic                       sweep_done,
    output logic                       overrun,
    input  logic [IDXW-1:0]            mon_idx,
    output logic [WIDTH-1:0]           mon_state
);

    typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} state_t;

    localparam logic [WIDTH:0]  THR      = (WIDTH+1)'(THRESHOLD);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);

    state_t                     state, state_nx;
    logic [WIDTH-1:0]           membrane [N_NEURONS];
    logic [N_NEURONS*WIDTH-1:0] cur_lat;
    logic [IDXW-1:0]            idx;
    logic [WIDTH-1:0]           m_cur, c_cur, sat;
    logic [WIDTH:0]             sum;
    logic                       fire, last;
    logic                       start, idx_inc, mem_wr;

    assign m_cur = membrane[idx];
    assign c_cur = cur_lat[idx*WIDTH +: WIDTH];
    // m - (m >> LEAK_SHIFT) cannot underflow; the extra bit catches the carry for saturation
    assign sum   = {1'b0, m_cur - (m_cur >> LEAK_SHIFT)} + {1'b0, c_cur};
    assign sat   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    assign fire  = {1'b0, sat} >= THR;
    assign last  = (idx == LAST_IDX);

    assign mon_state = membrane[mon_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        idx_inc  = 1'b0;
        mem_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    start    = 1'b1;
                    state_nx = UPDATE;
                end
            end
            UPDATE: begin
                mem_wr = 1'b1;
                if (fire)      state_nx = EMIT;
                else if (last) state_nx = DONE;
                else           idx_inc  = 1'b1;
            end
            EMIT: begin
                if (spike_ready) begin
                    if (last) begin
                        state_nx = DONE;
                    end else begin
                        idx_inc  = 1'b1;
                        state_nx = UPDATE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) membrane[i] <= '0;
            cur_lat     <= '0;
            idx         <= '0;
            spike_idx   <= '0;
            spike_valid <= 1'b0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (start) begin
                cur_lat <= current_in;
                idx     <= '0;
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            if (mem_wr) membrane[idx] <= fire ? '0 : sat;
            if (mem_wr && fire) spike_idx <= idx;
            // outputs registered from next state so they align with the state they describe
            spike_valid <= (state_nx == EMIT);
            busy        <= (state_nx != IDLE);
            sweep_done  <= (state_nx == DONE);
            overrun     <= overrun | (tick & (state != IDLE));
        end
    end

endmodule
